// File: rtl/mem_io_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR interface.
// Services CPU read/write requests to asynchronous SRAM with a programmable
// number of wait states. The single word IO_ADDR is decoded as I/O: reads
// return the switches and writes update the hex display register.
//
// state   | meaning
// IDLE    | waiting for mem_ce; the request is latched on the accepting edge
// ACCESS  | SRAM strobes active for WAIT_STATES+1 cycles
// DONE    | ready pulse, strobes inactive
// RELEASE | waiting for mem_ce to drop so a held request is not repeated
module mem_io_responder #(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [15:0]       mar,
    input  logic [15:0]       mdr,
    input  logic [15:0]       switches,
    output logic [15:0]       data_to_cpu,
    output logic              ready,
    output logic [15:0]       hex_out,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [3:0]  cnt_q;
    logic        is_io;

    assign is_io = (mar == IO_ADDR);

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_ce) begin
                    state_d = is_io ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!mem_ce) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and ready decode from registers only, so they cannot glitch
    // on input changes.
    always_comb begin
        ready     = 1'b0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        if (state_q == DONE) begin
            ready = 1'b1;
        end
        if (state_q == ACCESS) begin
            sram_ce_n = 1'b0;
            sram_oe_n = we_q;
            sram_we_n = ~we_q;
        end
    end

    // Request latch, wait counter and registered data outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            data_to_cpu <= 16'h0000;
            hex_out     <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_ce) begin
                        addr_q  <= mar;
                        wdata_q <= mdr;
                        we_q    <= mem_we;
                        cnt_q   <= WAIT_INIT;
                        if (is_io) begin
                            if (mem_we) begin
                                hex_out <= mdr;
                            end else begin
                                data_to_cpu <= switches;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!we_q) begin
                        data_to_cpu <= sram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Upper address bits beyond ADDR_W are dropped, not faulted.
    assign sram_addr  = addr_q[ADDR_W-1:0];
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder: a default instance (two wait
// states) plus a zero-wait-state instance sharing the same stimulus.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] switches;
    logic [15:0] sram_rdata;

    logic [15:0] data_to_cpu,  data_to_cpu0;
    logic        ready,        ready0;
    logic [15:0] hex_out,      hex_out0;
    logic [15:0] sram_addr,    sram_addr0;
    logic [15:0] sram_wdata,   sram_wdata0;
    logic        sram_ce_n,    sram_ce_n0;
    logic        sram_oe_n,    sram_oe_n0;
    logic        sram_we_n,    sram_we_n0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_io_responder #(.ADDR_W(16), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) u_dut (
        .clk(clk), .reset(reset), .mem_ce(mem_ce), .mem_we(mem_we),
        .mar(mar), .mdr(mdr), .switches(switches),
        .data_to_cpu(data_to_cpu), .ready(ready), .hex_out(hex_out),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_io_responder #(.ADDR_W(16), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) u_dut0 (
        .clk(clk), .reset(reset), .mem_ce(mem_ce), .mem_we(mem_we),
        .mar(mar), .mdr(mdr), .switches(switches),
        .data_to_cpu(data_to_cpu0), .ready(ready0), .hex_out(hex_out0),
        .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0)
    );

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int rdy_cnt;
        int ce_cnt;
        int budget;

        // 1: reset held with a request pending
        reset = 1'b0; mem_ce = 1'b1; mem_we = 1'b0;
        mar = 16'h0040; mdr = 16'h0000; switches = 16'h0000; sram_rdata = 16'hBEEF;
        tick();
        tick();
        chk("rst_ready", {15'd0, ready}, 16'h0000);
        chk("rst_hex", hex_out, 16'h0000);
        chk("rst_data", data_to_cpu, 16'h0000);
        chk("rst_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0007);
        chk("rst_addr", sram_addr, 16'h0000);
        chk("rst_wdata", sram_wdata, 16'h0000);
        mem_ce = 1'b0;
        reset  = 1'b1;
        tick();
        chk("idle_ready", {15'd0, ready}, 16'h0000);

        // 2: SRAM read, two wait states
        mar = 16'h0040; mem_we = 1'b0; sram_rdata = 16'hBEEF; mem_ce = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rd_c%0d_strobes", c), {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0001);
            chk($sformatf("rd_c%0d_ready", c), {15'd0, ready}, 16'h0000);
            chk($sformatf("rd_c%0d_addr", c), sram_addr, 16'h0040);
            tick();
        end
        chk("rd_c4_ready", {15'd0, ready}, 16'h0001);
        chk("rd_c4_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0007);
        chk("rd_data", data_to_cpu, 16'hBEEF);
        mem_ce = 1'b0;
        tick();
        chk("rd_release_ready", {15'd0, ready}, 16'h0000);
        tick();

        // 3: SRAM write; request inputs change mid-access and must be ignored
        mar = 16'h0041; mdr = 16'h1234; mem_we = 1'b1; mem_ce = 1'b1; sram_rdata = 16'hDEAD;
        tick();
        mar = 16'h9999; mdr = 16'h5678; mem_we = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("wr_c%0d_strobes", c), {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0002);
            chk($sformatf("wr_c%0d_addr", c), sram_addr, 16'h0041);
            chk($sformatf("wr_c%0d_wdata", c), sram_wdata, 16'h1234);
            chk($sformatf("wr_c%0d_ready", c), {15'd0, ready}, 16'h0000);
            tick();
        end
        chk("wr_c4_ready", {15'd0, ready}, 16'h0001);
        chk("wr_data_kept", data_to_cpu, 16'hBEEF);
        chk("wr_hex_kept", hex_out, 16'h0000);
        mem_ce = 1'b0;
        tick();
        tick();

        // 4: I/O write then I/O read
        mar = 16'hFFFF; mdr = 16'h00A5; mem_we = 1'b1; mem_ce = 1'b1;
        tick();
        chk("iow_ready", {15'd0, ready}, 16'h0001);
        chk("iow_hex", hex_out, 16'h00A5);
        chk("iow_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0007);
        chk("iow_data_kept", data_to_cpu, 16'hBEEF);
        mem_ce = 1'b0;
        tick();
        tick();
        switches = 16'h0F0F; mem_we = 1'b0; mdr = 16'h3333; mem_ce = 1'b1;
        tick();
        chk("ior_ready", {15'd0, ready}, 16'h0001);
        chk("ior_data", data_to_cpu, 16'h0F0F);
        chk("ior_hex_kept", hex_out, 16'h00A5);
        chk("ior_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0007);
        mem_ce = 1'b0;
        tick();
        tick();

        // 5: held request gives exactly one access and one ready
        mar = 16'h0050; mem_we = 1'b0; sram_rdata = 16'h5555; mem_ce = 1'b1;
        rdy_cnt = 0;
        ce_cnt  = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (ready) rdy_cnt++;
            if (!sram_ce_n) ce_cnt++;
        end
        chk("held_ready_cnt", 16'(rdy_cnt), 16'd1);
        chk("held_access_cycles", 16'(ce_cnt), 16'd3);
        chk("held_data", data_to_cpu, 16'h5555);
        mem_ce = 1'b0;
        tick();
        tick();
        mar = 16'h0060; sram_rdata = 16'h6666; mem_ce = 1'b1;
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!ready && budget < 10);
        chk("next_req_latency", 16'(budget), 16'd4);
        chk("next_req_data", data_to_cpu, 16'h6666);
        mem_ce = 1'b0;
        tick();
        tick();

        // 6: reset in the second ACCESS cycle aborts the read
        mar = 16'h0070; sram_rdata = 16'h7777; mem_ce = 1'b1;
        tick();
        tick();
        chk("abort_in_access", {15'd0, sram_ce_n}, 16'h0000);
        reset  = 1'b0;
        mem_ce = 1'b0;
        tick();
        chk("abort_ready", {15'd0, ready}, 16'h0000);
        chk("abort_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'h0007);
        chk("abort_data", data_to_cpu, 16'h0000);
        reset = 1'b1;
        rdy_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ready) rdy_cnt++;
        end
        chk("abort_no_ready", 16'(rdy_cnt), 16'd0);
        chk("abort_data_after", data_to_cpu, 16'h0000);

        // 6b: zero-wait-state instance, read completes in cycle 2
        mar = 16'h0040; mem_we = 1'b0; sram_rdata = 16'hBEEF; mem_ce = 1'b1;
        tick();
        chk("w0_c1_strobes", {13'd0, sram_ce_n0, sram_oe_n0, sram_we_n0}, 16'h0001);
        chk("w0_c1_ready", {15'd0, ready0}, 16'h0000);
        tick();
        chk("w0_c2_ready", {15'd0, ready0}, 16'h0001);
        chk("w0_c2_strobes", {13'd0, sram_ce_n0, sram_oe_n0, sram_we_n0}, 16'h0007);
        chk("w0_data", data_to_cpu0, 16'hBEEF);
        mem_ce = 1'b0;
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
